// File: rtl/order_dispatch.sv
// Sequencer for one arithmetic instruction on the A/B/C unit: load operands, issue order, write back.
// Define ORDER_DISPATCH_STATS_EN to add done/error event counters for the panel.
module order_dispatch #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 100,
  parameter int unsigned TMO_W       = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_from_pu,
  input  logic [2:0]  opcode_from_pu,
  input  logic        mem_ready_from_mem,
  input  logic        au_answer_from_ctrl,
  output logic        mem_read_req_to_mem,
  output logic        mem_write_req_to_mem,
  output logic [1:0]  mem_addr_sel_to_mem,
  output logic        clear_a_to_ctrl,
  output logic        move_c_to_a_to_ctrl,
  output logic        move_c_to_b_to_ctrl,
  output logic        move_b_to_c_to_ctrl,
  output logic        order_add_to_ctrl,
  output logic        order_sub_to_ctrl,
  output logic        order_mul_to_ctrl,
  output logic        order_div_to_ctrl,
  output logic        order_and_to_ctrl,
  output logic        busy_to_pu,
  output logic        done_to_pu,
`ifdef ORDER_DISPATCH_STATS_EN
  output logic [15:0] ops_done_cnt_to_pnl,
  output logic [15:0] ops_err_cnt_to_pnl,
`endif
  output logic        error_to_pu
);

  typedef enum logic [12:0] {
    StIdle   = 13'b0000000000001,
    StClr    = 13'b0000000000010,
    StSettle = 13'b0000000000100,
    StRd1    = 13'b0000000001000,
    StMva    = 13'b0000000010000,
    StRd2    = 13'b0000000100000,
    StMvb    = 13'b0000001000000,
    StOrd    = 13'b0000010000000,
    StWait   = 13'b0000100000000,
    StFix    = 13'b0001000000000,
    StWr     = 13'b0010000000000,
    StDone   = 13'b0100000000000,
    StErr    = 13'b1000000000000
  } state_e;

  localparam logic [3:0]       SettleLoad = 4'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0] TmoLast    = TMO_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [2:0]       opcode_q;
  logic [3:0]       settle_q;
  logic [TMO_W-1:0] tmo_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_from_pu) state_d = (opcode_from_pu <= 3'd4) ? StClr : StErr;
      StClr:    state_d = StSettle;
      StSettle: if (settle_q == 4'd0) state_d = StRd1;
      StRd1:    if (mem_ready_from_mem) state_d = StMva;
      StMva:    state_d = StRd2;
      StRd2:    if (mem_ready_from_mem) state_d = StMvb;
      StMvb:    state_d = StOrd;
      StOrd:    state_d = StWait;
      StWait: begin
        // An answer arriving on the expiry cycle still counts as success.
        if (au_answer_from_ctrl) begin
          state_d = (opcode_q == 3'd3 || opcode_q == 3'd4) ? StFix : StWr;
        end else if (tmo_q == TmoLast) begin
          state_d = StErr;
        end
      end
      StFix:    state_d = StWr;
      StWr:     if (mem_ready_from_mem) state_d = StDone;
      StDone:   state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q              <= StIdle;
      opcode_q             <= 3'd0;
      settle_q             <= 4'd0;
      tmo_q                <= '0;
      mem_read_req_to_mem  <= 1'b0;
      mem_write_req_to_mem <= 1'b0;
      mem_addr_sel_to_mem  <= 2'd0;
      clear_a_to_ctrl      <= 1'b0;
      move_c_to_a_to_ctrl  <= 1'b0;
      move_c_to_b_to_ctrl  <= 1'b0;
      move_b_to_c_to_ctrl  <= 1'b0;
      order_add_to_ctrl    <= 1'b0;
      order_sub_to_ctrl    <= 1'b0;
      order_mul_to_ctrl    <= 1'b0;
      order_div_to_ctrl    <= 1'b0;
      order_and_to_ctrl    <= 1'b0;
      busy_to_pu           <= 1'b0;
      done_to_pu           <= 1'b0;
      error_to_pu          <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start_from_pu) opcode_q <= opcode_from_pu;
      if (state_d == StSettle) settle_q <= (state_q == StSettle) ? settle_q - 4'd1 : SettleLoad;
      tmo_q <= (state_q == StWait) ? tmo_q + 1'b1 : '0;

      mem_read_req_to_mem  <= (state_d == StRd1 && state_q != StRd1) ||
                              (state_d == StRd2 && state_q != StRd2);
      mem_write_req_to_mem <= (state_d == StWr && state_q != StWr);
      mem_addr_sel_to_mem  <= (state_d == StRd2) ? 2'd1 : (state_d == StWr) ? 2'd2 : 2'd0;
      clear_a_to_ctrl      <= (state_d == StClr);
      move_c_to_a_to_ctrl  <= (state_d == StMva);
      move_c_to_b_to_ctrl  <= (state_d == StMvb);
      move_b_to_c_to_ctrl  <= (state_d == StFix);
      order_add_to_ctrl    <= (state_d == StOrd) && (opcode_q == 3'd0);
      order_sub_to_ctrl    <= (state_d == StOrd) && (opcode_q == 3'd1);
      order_mul_to_ctrl    <= (state_d == StOrd) && (opcode_q == 3'd2);
      order_div_to_ctrl    <= (state_d == StOrd) && (opcode_q == 3'd3);
      order_and_to_ctrl    <= (state_d == StOrd) && (opcode_q == 3'd4);
      busy_to_pu           <= (state_d != StIdle);
      done_to_pu           <= (state_d == StDone);
      error_to_pu          <= (state_d == StErr);
    end
  end

`ifdef ORDER_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ops_done_cnt_to_pnl <= 16'd0;
      ops_err_cnt_to_pnl  <= 16'd0;
    end else begin
      if (done_to_pu)  ops_done_cnt_to_pnl <= ops_done_cnt_to_pnl + 16'd1;
      if (error_to_pu) ops_err_cnt_to_pnl  <= ops_err_cnt_to_pnl + 16'd1;
    end
  end
`endif

endmodule
